pipelined_adder_accum: RTL and testbench

//  Two-stage pipelined adder/subtractor/accumulator with valid/ready handshakes on both sides.

---
 rtl/alu_lab_pkg.sv | 20 ++
 rtl/pipe_stage.sv | 41 ++++
 rtl/pipelined_adder_accum.sv | 123 ++++++++++++
 tb/tb_pipelined_adder_accum.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_lab_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_lab_pkg
//  Description : Shared op-mode encoding for the lab datapath adder blocks.
//  Revision    : 1.0  initial release
// ============================================================================
package alu_lab_pkg;

  localparam int MODE_W = 2;

  // Operation select carried with each operand beat
  typedef enum logic [MODE_W-1:0] {
    MODE_ADD = 2'd0,
    MODE_SUB = 2'd1,
    MODE_ACC = 2'd2,
    MODE_CLR = 2'd3
  } mode_e;

endpackage
`default_nettype wire

// File: rtl/pipe_stage.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_stage
//  Description : One valid/ready register slice. The parent computes the
//                advance enable; data is only captured with a valid beat so
//                the payload stays quiet while the slice is idle or stalled.
//  Revision    : 1.0  initial release
// ============================================================================
module pipe_stage #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             adv_i,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o
);

  logic             valid_q;
  logic [WIDTH-1:0] data_q;

  // Capture the incoming beat whenever the slice is allowed to advance
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (adv_i) begin
      valid_q <= valid_i;
      if (valid_i) begin
        data_q <= data_i;
      end
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule
`default_nettype wire

// File: rtl/pipelined_adder_accum.sv
`default_nettype none
// ============================================================================
//  Module      : pipelined_adder_accum
//  Description : Two-stage add/sub/accumulate pipeline with valid/ready on
//                both sides. Stage 1 registers the operands, the arithmetic
//                and accumulator update happen on the stage-1 -> stage-2
//                transfer, stage 2 registers {ovf, sum}.
//  Revision    : 1.0  initial release
// ============================================================================
module pipelined_adder_accum
  import alu_lab_pkg::*;
#(
  parameter int W = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                valid_i,
  output logic                ready_o,
  input  logic [MODE_W-1:0]   mode_i,
  input  logic [W-1:0]        a_i,
  input  logic [W-1:0]        b_i,
  output logic                valid_o,
  input  logic                ready_i,
  output logic [W:0]          sum_o,
  output logic                is_odd_o,
  output logic                ovf_o
);

  localparam int S1_W = MODE_W + 2 * W;  // {mode, a, b}
  localparam int S2_W = W + 2;           // {ovf, sum}

  logic              v1;
  logic              v2;
  logic              adv1;
  logic              adv2;
  logic [S1_W-1:0]   s1_data;
  logic [S2_W-1:0]   s2_data;

  mode_e             s1_mode;
  logic [W-1:0]      s1_a;
  logic [W-1:0]      s1_b;

  logic [W:0]        acc_q;
  logic [W:0]        acc_d;
  logic [W:0]        res_d;
  logic              ovf_d;
  logic [W+1:0]      acc_sum;

  // A slice may move when the one downstream of it is empty or draining;
  // ready_o depends only on pipe state, never on valid_i.
  assign adv2    = !v2 | ready_i;
  assign adv1    = !v1 | adv2;
  assign ready_o = adv1;

  pipe_stage #(
    .WIDTH (S1_W)
  ) u_stage1 (
    .clk     (clk),
    .reset   (reset),
    .adv_i   (adv1),
    .valid_i (valid_i),
    .data_i  ({mode_i, a_i, b_i}),
    .valid_o (v1),
    .data_o  (s1_data)
  );

  assign s1_mode = mode_e'(s1_data[S1_W-1 -: MODE_W]);
  assign s1_a    = s1_data[2*W-1 -: W];
  assign s1_b    = s1_data[W-1:0];

  // Accumulator sum is one bit wider so the wrap out of bit W is visible
  assign acc_sum = {1'b0, acc_q} + {2'b00, s1_a};

  // Mode mux: result, wrap flag and next accumulator for the beat in stage 1
  always_comb begin
    res_d = '0;
    ovf_d = 1'b0;
    acc_d = acc_q;
    case (s1_mode)
      MODE_ADD: res_d = {1'b0, s1_a} + {1'b0, s1_b};
      MODE_SUB: res_d = {1'b0, s1_a} - {1'b0, s1_b};
      MODE_ACC: begin
        res_d = acc_sum[W:0];
        ovf_d = acc_sum[W+1];
        acc_d = acc_sum[W:0];
      end
      MODE_CLR: begin
        res_d = acc_q;
        acc_d = '0;
      end
      default: res_d = '0;
    endcase
  end

  // The accumulator moves exactly when a valid beat enters stage 2, so
  // back-to-back ACC beats see each other's result without a hazard.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q <= '0;
    end else if (adv2 && v1) begin
      acc_q <= acc_d;
    end
  end

  pipe_stage #(
    .WIDTH (S2_W)
  ) u_stage2 (
    .clk     (clk),
    .reset   (reset),
    .adv_i   (adv2),
    .valid_i (v1),
    .data_i  ({ovf_d, res_d}),
    .valid_o (v2),
    .data_o  (s2_data)
  );

  assign valid_o  = v2;
  assign sum_o    = s2_data[W:0];
  assign ovf_o    = s2_data[W+1];
  assign is_odd_o = s2_data[0];

endmodule
`default_nettype wire

// File: tb/tb_pipelined_adder_accum.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipelined_adder_accum
//  Description : Directed self-checking bench for pipelined_adder_accum.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pipelined_adder_accum;
  import alu_lab_pkg::*;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         valid_i;
  logic         ready_o;
  logic [1:0]   mode_i;
  logic [W-1:0] a_i;
  logic [W-1:0] b_i;
  logic         valid_o;
  logic         ready_i;
  logic [W:0]   sum_o;
  logic         is_odd_o;
  logic         ovf_o;

  int checks = 0;
  int errors = 0;

  logic [W:0]   acc_m;
  logic [9:0]   q6[$];

  always #5 clk = ~clk;

  pipelined_adder_accum #(.W(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .valid_i  (valid_i),
    .ready_o  (ready_o),
    .mode_i   (mode_i),
    .a_i      (a_i),
    .b_i      (b_i),
    .valid_o  (valid_o),
    .ready_i  (ready_i),
    .sum_o    (sum_o),
    .is_odd_o (is_odd_o),
    .ovf_o    (ovf_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] m, input logic [7:0] a, input logic [7:0] b);
    valid_i = 1'b1;
    mode_i  = m;
    a_i     = a;
    b_i     = b;
  endtask

  task automatic chk_res(input string tag, input logic [8:0] esum, input logic eovf);
    chk({tag, "_valid"}, {31'd0, valid_o}, 32'd1);
    chk({tag, "_sum"},   {23'd0, sum_o},   {23'd0, esum});
    chk({tag, "_odd"},   {31'd0, is_odd_o}, {31'd0, esum[0]});
    chk({tag, "_ovf"},   {31'd0, ovf_o},   {31'd0, eovf});
  endtask

  // Single beat into an idle pipe: nothing after one cycle, result after two
  task automatic one_beat(input string tag, input logic [1:0] m, input logic [7:0] a,
                          input logic [7:0] b, input logic [8:0] esum, input logic eovf);
    drive(m, a, b);
    step;
    valid_i = 1'b0;
    chk({tag, "_lat1"}, {31'd0, valid_o}, 32'd0);
    step;
    chk_res(tag, esum, eovf);
  endtask

  // Reference model returning {ovf, sum}
  function automatic logic [9:0] ref_beat(input logic [1:0] m, input logic [7:0] a,
                                          input logic [7:0] b);
    logic [9:0] t;
    case (m)
      2'd0: t = {2'b00, a} + {2'b00, b};
      2'd1: begin
        t = {2'b00, a} - {2'b00, b};
        t[9] = 1'b0;
      end
      2'd2: begin
        t = {1'b0, acc_m} + {2'b00, a};
        acc_m = t[8:0];
      end
      default: begin
        t = {1'b0, acc_m};
        acc_m = '0;
      end
    endcase
    return t;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] m5[4];
    logic [7:0] a5[4];
    logic [7:0] b5[4];
    logic [8:0] e5[4];
    logic [9:0] e;
    int idx, outn, sent, got, gaps, stalls, started;

    // ---------------- 1: reset, mid-stream reset ----------------
    reset = 1'b1; valid_i = 1'b0; ready_i = 1'b1;
    mode_i = '0; a_i = '0; b_i = '0;
    step; step;
    chk("rst_valid", {31'd0, valid_o}, 32'd0);
    chk("rst_sum",   {23'd0, sum_o},   32'd0);
    chk("rst_odd",   {31'd0, is_odd_o}, 32'd0);
    chk("rst_ovf",   {31'd0, ovf_o},   32'd0);
    reset = 1'b0;
    #1;
    chk("rst_ready", {31'd0, ready_o}, 32'd1);

    drive(MODE_ADD, 8'd3, 8'd4);
    step;
    drive(MODE_ADD, 8'd5, 8'd6);
    step;
    valid_i = 1'b0;
    chk("inflight_valid", {31'd0, valid_o}, 32'd1);
    reset = 1'b1;
    #1;
    chk("midrst_valid", {31'd0, valid_o}, 32'd0);
    chk("midrst_sum",   {23'd0, sum_o},   32'd0);
    step;
    reset = 1'b0;
    #1;
    chk("midrst_ready", {31'd0, ready_o}, 32'd1);
    chk("midrst_drop",  {31'd0, valid_o}, 32'd0);
    one_beat("clr0", MODE_CLR, 8'd0, 8'd0, 9'd0, 1'b0);
    step;
    chk("clr0_nodup", {31'd0, valid_o}, 32'd0);

    // ---------------- 2: ADD ----------------
    one_beat("add300", MODE_ADD, 8'd200, 8'd100, 9'd300, 1'b0);
    one_beat("add510", MODE_ADD, 8'd255, 8'd255, 9'd510, 1'b0);

    // ---------------- 3: SUB ----------------
    one_beat("sub5",   MODE_SUB, 8'd8, 8'd3, 9'd5, 1'b0);
    one_beat("subneg", MODE_SUB, 8'd5, 8'd7, 9'h1FE, 1'b0);

    // ---------------- 4: ACC / CLR ----------------
    one_beat("acc1",  MODE_ACC, 8'd255, 8'd0, 9'd255, 1'b0);
    one_beat("acc2",  MODE_ACC, 8'd255, 8'd0, 9'd510, 1'b0);
    one_beat("acc3",  MODE_ACC, 8'd255, 8'd0, 9'd253, 1'b1);
    one_beat("clr",   MODE_CLR, 8'd0,   8'd0, 9'd253, 1'b0);
    one_beat("acc_1", MODE_ACC, 8'd1,   8'd0, 9'd1,   1'b0);
    step;
    valid_i = 1'b0;

    // ---------------- 5: back-pressure ----------------
    m5[0] = MODE_ADD; a5[0] = 8'd1;  b5[0] = 8'd1;  e5[0] = 9'd2;
    m5[1] = MODE_ADD; a5[1] = 8'd2;  b5[1] = 8'd2;  e5[1] = 9'd4;
    m5[2] = MODE_SUB; a5[2] = 8'd9;  b5[2] = 8'd4;  e5[2] = 9'd5;
    m5[3] = MODE_ADD; a5[3] = 8'd10; b5[3] = 8'd20; e5[3] = 9'd30;
    ready_i = 1'b0;
    #1;
    idx = 0;
    drive(m5[0], a5[0], b5[0]);
    for (int c = 0; c < 6; c++) begin
      if (valid_i && ready_o) idx++;
      step;
      if (idx < 4) drive(m5[idx], a5[idx], b5[idx]);
      else valid_i = 1'b0;
      if (c >= 1) begin
        chk("stall_valid", {31'd0, valid_o}, 32'd1);
        chk("stall_sum",   {23'd0, sum_o},   32'd2);
      end
    end
    chk("stall_accepted", idx, 32'd2);
    chk("stall_ready",    {31'd0, ready_o}, 32'd0);

    ready_i = 1'b1;
    #1;
    outn = 0;
    for (int c = 0; c < 20 && outn < 4; c++) begin
      if (valid_o) begin
        chk("drain_sum", {23'd0, sum_o}, {23'd0, e5[outn]});
        outn++;
      end
      if (valid_i && ready_o) idx++;
      step;
      if (idx < 4) drive(m5[idx], a5[idx], b5[idx]);
      else valid_i = 1'b0;
    end
    chk("drain_count", outn, 32'd4);
    chk("drain_nodup", {31'd0, valid_o}, 32'd0);

    // ---------------- 6: random back-to-back ----------------
    acc_m = 9'd1;
    sent = 0; got = 0; gaps = 0; stalls = 0; started = 0;
    drive(2'($urandom_range(0, 2)), 8'($urandom), 8'($urandom));
    for (int c = 0; c < 80 && got < 20; c++) begin
      if (valid_o) begin
        if (q6.size() == 0) begin
          chk("rnd_spurious", {31'd0, valid_o}, 32'd0);
        end else begin
          e = q6.pop_front();
          chk("rnd_sum", {23'd0, sum_o}, {23'd0, e[8:0]});
          chk("rnd_odd", {31'd0, is_odd_o}, {31'd0, e[0]});
          chk("rnd_ovf", {31'd0, ovf_o}, {31'd0, e[9]});
        end
        got++;
        started = 1;
      end else if (started != 0) begin
        gaps++;
      end
      if (valid_i && ready_o) begin
        q6.push_back(ref_beat(mode_i, a_i, b_i));
        sent++;
      end else if (valid_i) begin
        stalls++;
      end
      step;
      if (sent < 20) drive(2'($urandom_range(0, 2)), 8'($urandom), 8'($urandom));
      else valid_i = 1'b0;
    end
    chk("rnd_count",  got,    32'd20);
    chk("rnd_gaps",   gaps,   32'd0);
    chk("rnd_stalls", stalls, 32'd0);
    chk("rnd_drain",  {31'd0, valid_o}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
